// File: rtl/cover_pkg.sv
// cover_pkg: shared FSM states, bitmap word width and index-width helper
package cover_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, CLEAR} state_t;
  localparam int BITMAP_WORD_W = 32;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cover_idx_fifo.sv
// cover_idx_fifo: synchronous index FIFO with full/empty flags and flush
module cover_idx_fifo import cover_pkg::*; #(
  parameter int DW = 8,
  parameter int DEPTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);
  localparam int PW = idx_width(DEPTH);
  logic [PW:0] r_wr;
  logic [PW:0] r_rd;
  logic [DW-1:0] r_mem [DEPTH];
  logic w_push;
  logic w_pop;
  assign o_empty = r_wr == r_rd;
  assign o_full = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_data = r_mem[r_rd[PW-1:0]];
  // Pointer and storage update; flush empties without touching storage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr[PW-1:0]] <= i_data;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end
endmodule

// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector: first-hit toggle coverage bitmap with new-hit FIFO, readback and clear sweep
module cover_toggle_collector import cover_pkg::*; #(
  parameter int W = 4,
  parameter int COVER_TOTAL = 256,
  parameter int FIFO_DEPTH = 8,
  localparam int IDX_W = idx_width(COVER_TOTAL),
  localparam int WORDS = COVER_TOTAL / BITMAP_WORD_W,
  localparam int AW = idx_width(WORDS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_bits,
  input  logic [IDX_W-1:0]         in_base,
  output logic                     new_valid,
  input  logic                     new_ready,
  output logic [IDX_W-1:0]         new_index,
  input  logic                     clear_req,
  output logic                     clear_busy,
  input  logic                     rd_en,
  input  logic [AW-1:0]            rd_addr,
  output logic                     rd_valid,
  output logic [BITMAP_WORD_W-1:0] rd_data,
  output logic [IDX_W:0]           cover_count
);
  localparam int PW = idx_width(W);
  state_t r_state;
  state_t w_next;
  logic r_run;
  logic r_pending;
  logic [IDX_W-1:0] r_base;
  logic [W-1:0] r_bits;
  logic [W-1:0] w_mask;
  logic [W-1:0] w_rest;
  logic [PW-1:0] w_p;
  logic [IDX_W-1:0] w_idx;
  logic [COVER_TOTAL-1:0] r_bitmap;
  logic [IDX_W:0] r_count;
  logic [AW-1:0] r_clr_addr;
  logic r_rd_valid;
  logic [BITMAP_WORD_W-1:0] r_rd_data;
  logic w_full;
  logic w_empty;
  logic w_hit;
  logic w_adv;
  logic w_push;
  logic w_accept;
  logic w_flush;
  logic w_clr_last;
  assign in_ready = r_run && r_state == IDLE && !r_pending;
  assign clear_busy = r_pending || r_state == CLEAR;
  assign new_valid = !w_empty;
  assign cover_count = r_count;
  assign rd_valid = r_rd_valid;
  assign rd_data = r_rd_data;
  // Range-mask incoming bits, pick lowest pending bit, and choose next state
  always_comb begin
    w_mask = '0;
    w_p = '0;
    for (int i = 0; i < W; i++) w_mask[i] = in_bits[i] && (int'(in_base) + i < COVER_TOTAL);
    for (int i = W - 1; i >= 0; i--) if (r_bits[i]) w_p = PW'(i);
    w_idx = r_base + IDX_W'(w_p);
    w_rest = r_bits & ~(W'(1) << w_p);
    w_hit = r_bitmap[w_idx];
    w_adv = r_state == SCAN && (w_hit || !w_full);
    w_push = r_state == SCAN && !w_hit && !w_full;
    w_accept = in_valid && in_ready;
    w_flush = r_state == CLEAR && r_clr_addr == '0;
    w_clr_last = r_clr_addr == AW'(WORDS - 1);
    w_next = r_state == IDLE ? (r_pending ? CLEAR : (w_accept && |w_mask) ? SCAN : IDLE)
           : r_state == SCAN ? ((w_adv && w_rest == '0) ? (r_pending ? CLEAR : IDLE) : SCAN)
           : (w_clr_last ? IDLE : CLEAR);
  end
  // State, event latch, bitmap set/sweep and distinct-hit count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_run <= 1'b0;
      r_pending <= 1'b0;
      r_base <= '0;
      r_bits <= '0;
      r_bitmap <= '0;
      r_count <= '0;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_next;
      r_run <= 1'b1;
      r_pending <= clear_req || (r_pending && !w_flush);
      if (w_accept) begin
        r_base <= in_base;
        r_bits <= w_mask;
      end else if (w_adv) begin
        r_bits <= w_rest;
      end
      if (w_push) begin
        r_bitmap[w_idx] <= 1'b1;
        r_count <= r_count + 1'b1;
      end
      if (r_state == CLEAR) begin
        r_bitmap[BITMAP_WORD_W * int'(r_clr_addr) +: BITMAP_WORD_W] <= '0;
        r_clr_addr <= w_clr_last ? '0 : r_clr_addr + 1'b1;
      end
      if (w_flush) r_count <= '0;
    end
  end
  // Word readback sees the bitmap as it was before this cycle's updates
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= (int'(rd_addr) < WORDS) ? r_bitmap[BITMAP_WORD_W * int'(rd_addr) +: BITMAP_WORD_W] : '0;
    end
  end
  cover_idx_fifo #(.DW(IDX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .i_push(w_push),
    .i_data(w_idx),
    .i_pop(new_ready),
    .i_flush(w_flush),
    .o_data(new_index),
    .o_full(w_full),
    .o_empty(w_empty)
  );
endmodule

// File: tb/tb_cover_toggle_collector.sv
// tb_cover_toggle_collector: directed checks of hit dedup, FIFO stall, range mask, clear and reset
module tb_cover_toggle_collector;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic new_ready = 1'b0;
  logic clear_req = 1'b0;
  logic rd_en = 1'b0;
  logic [3:0] in_bits = '0;
  logic [7:0] in_base = '0;
  logic [2:0] rd_addr = '0;
  logic in_ready;
  logic new_valid;
  logic clear_busy;
  logic rd_valid;
  logic [7:0] new_index;
  logic [31:0] rd_data;
  logic [8:0] cover_count;
  int n_tests = 0;
  int n_fail = 0;
  int busy_cycles;
  logic [7:0] exp_q[$];
  always #5 clock = ~clock;
  cover_toggle_collector dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_bits(in_bits),
    .in_base(in_base),
    .new_valid(new_valid),
    .new_ready(new_ready),
    .new_index(new_index),
    .clear_req(clear_req),
    .clear_busy(clear_busy),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .cover_count(cover_count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic [3:0] v);
    int t = 0;
    in_base = b;
    in_bits = v;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("send_accept", 64'(in_ready), 64'd1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask
  task automatic wait_ready();
    busy_cycles = 0;
    while (!in_ready && busy_cycles < 200) begin
      @(negedge clock);
      busy_cycles++;
    end
    chk("wait_ready", 64'(in_ready), 64'd1);
  endtask
  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    rd_en = 1'b1;
    rd_addr = a;
    @(negedge clock);
    rd_en = 1'b0;
    chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
    chk(tag, 64'(rd_data), 64'(exp));
  endtask
  task automatic drain();
    int t = 0;
    int got = 0;
    new_ready = 1'b1;
    while (got < exp_q.size() && t < 200) begin
      if (new_valid) begin
        chk("new_index", 64'(new_index), 64'(exp_q[got]));
        got++;
      end
      @(negedge clock);
      t++;
    end
    new_ready = 1'b0;
    chk("drain_count", 64'(got), 64'(exp_q.size()));
    chk("drain_empty", 64'(new_valid), 64'd0);
  endtask
  task automatic clear_from_idle();
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    busy_cycles = 0;
    while (clear_busy && busy_cycles < 200) begin
      @(negedge clock);
      busy_cycles++;
    end
  endtask
  initial begin
    @(negedge clock);
    @(negedge clock);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_new_valid", 64'(new_valid), 64'd0);
    chk("rst_count", 64'(cover_count), 64'd0);
    chk("rst_busy", 64'(clear_busy), 64'd0);
    chk("rst_rd", 64'({rd_valid, rd_data}), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    send(8'd8, 4'b1011);
    wait_ready();
    chk("t1_scan_cycles", 64'(busy_cycles), 64'd3);
    chk("t1_count", 64'(cover_count), 64'd3);
    exp_q = '{8'd8, 8'd9, 8'd11};
    drain();
    rd(3'd0, 32'h0000_0B00, "t1_word0");
    @(negedge clock);
    chk("t1_rd_valid_drop", 64'(rd_valid), 64'd0);
    send(8'd8, 4'b1011);
    wait_ready();
    chk("t2_dup_count", 64'(cover_count), 64'd3);
    chk("t2_dup_nopush", 64'(new_valid), 64'd0);
    send(8'd9, 4'b0011);
    wait_ready();
    chk("t2_count", 64'(cover_count), 64'd4);
    exp_q = '{8'd10};
    drain();
    send(8'd16, 4'b1111);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    chk("t5_busy", 64'(clear_busy), 64'd1);
    chk("t5_in_ready", 64'(in_ready), 64'd0);
    wait_ready();
    chk("t5_busy_done", 64'(clear_busy), 64'd0);
    chk("t5_count", 64'(cover_count), 64'd0);
    chk("t5_flushed", 64'(new_valid), 64'd0);
    for (int i = 0; i < 8; i++) rd(3'(i), 32'h0, "t5_word_zero");
    send(8'd8, 4'b0001);
    wait_ready();
    chk("t5_repush_count", 64'(cover_count), 64'd1);
    exp_q = '{8'd8};
    drain();
    clear_from_idle();
    chk("clr_latency", 64'(busy_cycles), 64'd9);
    chk("clr_count", 64'(cover_count), 64'd0);
    send(8'd0, 4'b1111);
    wait_ready();
    send(8'd4, 4'b1111);
    wait_ready();
    send(8'd8, 4'b1111);
    repeat (3) @(negedge clock);
    chk("t3_stall_ready", 64'(in_ready), 64'd0);
    chk("t3_stall_count", 64'(cover_count), 64'd8);
    chk("t3_stall_valid", 64'(new_valid), 64'd1);
    chk("t3_stall_head", 64'(new_index), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(8'(i));
    drain();
    wait_ready();
    chk("t3_count", 64'(cover_count), 64'd12);
    rd(3'd0, 32'h0000_0FFF, "t3_word0");
    send(8'd254, 4'b1111);
    wait_ready();
    chk("t4_scan_cycles", 64'(busy_cycles), 64'd2);
    chk("t4_count", 64'(cover_count), 64'd14);
    exp_q = '{8'd254, 8'd255};
    drain();
    rd(3'd7, 32'hC000_0000, "t4_word7");
    send(8'd40, 4'b0001);
    wait_ready();
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    repeat (3) @(negedge clock);
    chk("t6_mid_clear", 64'(clear_busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_busy", 64'(clear_busy), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd0);
    chk("t6_count", 64'(cover_count), 64'd0);
    chk("t6_new_valid", 64'(new_valid), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("t6_rel_ready", 64'(in_ready), 64'd1);
    chk("t6_rel_count", 64'(cover_count), 64'd0);
    chk("t6_rel_busy", 64'(clear_busy), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
